mem2_dp: RTL and testbench

MEM2_DP -- requirements
Module: mem2_dp

---
 rtl/mem2_dp.sv | 136 +++++++++++++
 tb/tb_mem2_dp.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem2_dp.sv
// rtl/mem2_dp.sv - dual-port byte-enabled RAM with post-reset zero sweep and 1/2-cycle read latency
// Optional MEM2_DP_FWD_EN: same-address read-during-write returns the merged new word.
module mem2_dp #(
  parameter int WIDTH  = 8,
  parameter int SIZE_E = 6,
  parameter int RD_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 WRITE,
  input  logic [WIDTH/8-1:0]   BE,
  input  logic [SIZE_E-1:0]    iWRAddr,
  input  logic [WIDTH-1:0]     D,
  input  logic                 READ,
  input  logic [SIZE_E-1:0]    iRDAddr,
  output logic [WIDTH-1:0]     Q,
  output logic                 QVALID,
  output logic                 BUSY
);

  localparam int DEPTH = 1 << SIZE_E;
  localparam int NB    = WIDTH / 8;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state, state_nxt;
  logic [SIZE_E:0]     cnt, cnt_nxt;
  logic [WIDTH-1:0]    mem [DEPTH];

  logic                wr_en;
  logic [SIZE_E-1:0]   wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic [NB-1:0]       wr_mask;
  logic                rd_fire;
  logic [WIDTH-1:0]    old_word;
  logic [WIDTH-1:0]    rd_word;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter stops once RUN is reached, so the sweep never repeats.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == CLEAR) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt[SIZE_E-1:0] == {SIZE_E{1'b1}})
        state_nxt = RUN;
    end
  end

  assign BUSY = (state == CLEAR);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = iWRAddr;
    wr_data = D;
    wr_mask = BE;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = cnt[SIZE_E-1:0];
      wr_data = '0;
      wr_mask = '1;
    end else begin
      wr_en = WRITE && (BE != '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_mask[b])
          mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_fire  = READ && (state == RUN);
  assign old_word = mem[iRDAddr];

`ifdef MEM2_DP_FWD_EN
  always_comb begin
    rd_word = old_word;
    if (WRITE && (state == RUN) && (iWRAddr == iRDAddr)) begin
      for (int b = 0; b < NB; b++) begin
        if (BE[b])
          rd_word[8*b +: 8] = D[8*b +: 8];
      end
    end
  end
`else
  assign rd_word = old_word;
`endif

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] s1_data;
      logic             s1_valid;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          s1_data  <= '0;
          s1_valid <= 1'b0;
          Q        <= '0;
          QVALID   <= 1'b0;
        end else begin
          s1_valid <= rd_fire;
          if (rd_fire)
            s1_data <= rd_word;
          QVALID <= s1_valid;
          if (s1_valid)
            Q <= s1_data;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          Q      <= '0;
          QVALID <= 1'b0;
        end else begin
          QVALID <= rd_fire;
          if (rd_fire)
            Q <= rd_word;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_mem2_dp.sv
// tb/tb_mem2_dp.sv - scoreboard bench for mem2_dp: default instance plus a 32-bit, 16-deep, RD_LAT=2 instance
module tb_mem2_dp;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

`ifdef MEM2_DP_FWD_EN
  localparam logic [7:0]  SAME0 = 8'hC3;
  localparam logic [31:0] SAME1 = 32'h11BBFFFF;
`else
  localparam logic [7:0]  SAME0 = 8'h3C;
  localparam logic [31:0] SAME1 = 32'h11BB33DD;
`endif

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        write0, read0, qvalid0, busy0;
  logic [0:0]  be0;
  logic [5:0]  wraddr0, rdaddr0;
  logic [7:0]  d0, q0_out;

  logic        write1, read1, qvalid1, busy1;
  logic [3:0]  be1;
  logic [3:0]  wraddr1, rdaddr1;
  logic [31:0] d1, q1_out;

  exp_t        sb0[$];
  exp_t        sb1[$];

  mem2_dp u0 (
    .CLK(clk), .RST(rst), .WRITE(write0), .BE(be0), .iWRAddr(wraddr0), .D(d0),
    .READ(read0), .iRDAddr(rdaddr0), .Q(q0_out), .QVALID(qvalid0), .BUSY(busy0)
  );

  mem2_dp #(.WIDTH(32), .SIZE_E(4), .RD_LAT(2)) u1 (
    .CLK(clk), .RST(rst), .WRITE(write1), .BE(be1), .iWRAddr(wraddr1), .D(d1),
    .READ(read1), .iRDAddr(rdaddr1), .Q(q1_out), .QVALID(qvalid1), .BUSY(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: every QVALID pulse must match the oldest outstanding expectation, in data and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (qvalid0) begin
      checks++;
      if (sb0.size() == 0) begin
        errors++;
        $display("FAIL u0_unexpected_qvalid cyc=%0d q=%h", cyc, q0_out);
      end else begin
        e = sb0.pop_front();
        if (q0_out !== e.data[7:0] || cyc != e.cyc) begin
          errors++;
          $display("FAIL u0_read got q=%h cyc=%0d expected q=%h cyc=%0d", q0_out, cyc, e.data[7:0], e.cyc);
        end
      end
    end
    if (qvalid1) begin
      checks++;
      if (sb1.size() == 0) begin
        errors++;
        $display("FAIL u1_unexpected_qvalid cyc=%0d q=%h", cyc, q1_out);
      end else begin
        e = sb1.pop_front();
        if (q1_out !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL u1_read got q=%h cyc=%0d expected q=%h cyc=%0d", q1_out, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    step();
    write0 = 1'b0; read0 = 1'b0; write1 = 1'b0; read1 = 1'b0;
  endtask

  task automatic wr0(input logic [5:0] a, input logic [7:0] d, input logic be);
    write0 = 1'b1; wraddr0 = a; d0 = d; be0 = be;
  endtask

  task automatic rd0(input logic [5:0] a, input logic [7:0] exp);
    read0 = 1'b1; rdaddr0 = a;
    sb0.push_back('{{24'h0, exp}, cyc + 1});
  endtask

  task automatic wr1(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    write1 = 1'b1; wraddr1 = a; d1 = d; be1 = be;
  endtask

  task automatic rd1(input logic [3:0] a, input logic [31:0] exp);
    read1 = 1'b1; rdaddr1 = a;
    sb1.push_back('{exp, cyc + 2});
  endtask

  // Counts BUSY-high negedges per instance after reset release; optionally holds READ on u0.
  task automatic busy_count(input bit rd_sweep);
    int n0 = 0;
    int n1 = 0;
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (busy0) n0++;
      if (busy1) n1++;
      read0   = rd_sweep && (i < 40);
      rdaddr0 = 6'd5;
      if (!busy0 && !busy1) done = 1'b1;
    end
    read0 = 1'b0;
    chk("u0_busy_cycles", n0, 64);
    chk("u1_busy_cycles", n1, 16);
    step();
  endtask

  initial begin
    rst = 1'b1;
    write0 = 0; read0 = 0; be0 = 0; wraddr0 = 0; rdaddr0 = 0; d0 = 0;
    write1 = 0; read1 = 0; be1 = 0; wraddr1 = 0; rdaddr1 = 0; d1 = 0;
    repeat (3) step();
    chk("rst_q0", q0_out, 0);
    chk("rst_qvalid0", qvalid0, 0);
    chk("rst_busy0", busy0, 1);
    chk("rst_q1", q1_out, 0);
    chk("rst_qvalid1", qvalid1, 0);
    chk("rst_busy1", busy1, 1);

    rst = 1'b0;
    busy_count(1'b0);

    rd0(6'd9, 8'h00);          tick();
    rd0(6'd63, 8'h00);         tick();
    rd1(4'd15, 32'h0);         tick();
    wr0(6'd5, 8'hA5, 1'b1);    tick();
    rd0(6'd5, 8'hA5);          tick();
    wr0(6'd6, 8'h77, 1'b0);    tick();
    rd0(6'd6, 8'h00);          tick();
    wr0(6'd7, 8'h3C, 1'b1);    tick();
    wr0(6'd7, 8'hC3, 1'b1); rd0(6'd7, SAME0); tick();
    rd0(6'd7, 8'hC3);          tick();
    wr0(6'd8, 8'h5A, 1'b1); rd0(6'd5, 8'hA5); tick();
    rd0(6'd8, 8'h5A);          tick();
    tick(); tick();
    @(negedge clk);
    chk("u0_q_hold", q0_out, 8'h5A);
    chk("u0_qvalid_idle", qvalid0, 0);
    step();

    wr1(4'd3, 32'h11223344, 4'hF); tick();
    wr1(4'd3, 32'hAABBCCDD, 4'b0101); tick();
    rd1(4'd3, 32'h11BB33DD);   tick();
    wr1(4'd0, 32'h00000001, 4'hF); tick();
    wr1(4'd1, 32'h00000002, 4'hF); tick();
    wr1(4'd2, 32'h00000003, 4'hF); tick();
    rd1(4'd0, 32'h00000001);   tick();
    rd1(4'd1, 32'h00000002);   tick();
    rd1(4'd2, 32'h00000003);   tick();
    wr1(4'd3, 32'hFFFFFFFF, 4'b0011); rd1(4'd3, SAME1); tick();
    repeat (4) tick();

    // Read in flight on u1 when reset hits: it must never come out.
    read1 = 1'b1; rdaddr1 = 4'd0;
    step();
    read1 = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrun_rst_q1", q1_out, 0);
    chk("midrun_rst_qvalid1", qvalid1, 0);
    chk("midrun_rst_busy0", busy0, 1);
    repeat (2) step();
    rst = 1'b0;
    read0 = 1'b1; rdaddr0 = 6'd5;
    repeat (30) step();
    read0 = 1'b0;
    chk("sweep30_busy0", busy0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    busy_count(1'b1);

    rd0(6'd5, 8'h00);          tick();
    rd1(4'd3, 32'h0);          tick();
    repeat (5) tick();
    chk("u0_sb_drained", sb0.size(), 0);
    chk("u1_sb_drained", sb1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
